// File: rtl/up_down_counter_spec.sv
// Loadable 8-bit up/down counter with a one-cycle wrap pulse.
// The first clock edge after reset loads the start value; later edges add or subtract the step.
module up_down_counter_spec (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       up,
    input  logic       dn,
    output logic [7:0] q,
    output logic       overflow
);

    // state   | meaning
    // ST_LOAD | reset released, next edge captures a into q
    // ST_RUN  | loaded, counting by b on up/dn requests
    typedef enum logic {
        ST_LOAD = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t     state, state_nxt;
    logic [7:0] q_nxt;
    logic       ovf_nxt;
    logic [8:0] sum;
    logic [8:0] diff;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= ST_LOAD;
            q        <= 8'd0;
            overflow <= 1'b0;
        end else begin
            state    <= state_nxt;
            q        <= q_nxt;
            overflow <= ovf_nxt;
        end
    end

    // The ninth bit of each result is the carry (up) or borrow (down).
    assign sum  = {1'b0, q} + {1'b0, b};
    assign diff = {1'b0, q} - {1'b0, b};

    always_comb begin
        state_nxt = state;
        q_nxt     = q;
        ovf_nxt   = 1'b0;
        unique case (state)
            ST_LOAD: begin
                q_nxt     = a;
                state_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (up && !dn) begin
                    q_nxt   = sum[7:0];
                    ovf_nxt = sum[8];
                end else if (dn && !up) begin
                    q_nxt   = diff[7:0];
                    ovf_nxt = diff[8];
                end
            end
            default: state_nxt = ST_LOAD;
        endcase
    end

endmodule

// File: tb/tb_up_down_counter_spec.sv
// Bench for up_down_counter_spec: directed vector table, async-reset sequence,
// and random traffic against an arithmetic reference model.
module tb_up_down_counter_spec;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] a = 8'd0;
    logic [7:0] b = 8'd0;
    logic       up = 1'b0;
    logic       dn = 1'b0;
    logic [7:0] q;
    logic       overflow;

    int tests  = 0;
    int failed = 0;

    up_down_counter_spec dut (
        .clk      (clk),
        .rst      (rst),
        .a        (a),
        .b        (b),
        .up       (up),
        .dn       (dn),
        .q        (q),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic [7:0] a;
        logic [7:0] b;
        logic       up;
        logic       dn;
        logic [7:0] exp_q;
        logic       exp_ovf;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic r, int va, int vb, logic vu, logic vd, int eq, logic eo);
        vec_t v;
        v.rst = r; v.a = 8'(va); v.b = 8'(vb); v.up = vu; v.dn = vd;
        v.exp_q = 8'(eq); v.exp_ovf = eo;
        return v;
    endfunction

    task automatic chk(string name, logic [7:0] exp_q, logic exp_ovf);
        tests++;
        if (q !== exp_q || overflow !== exp_ovf) begin
            failed++;
            $display("FAIL %s: got q=%0d ovf=%0b, expected q=%0d ovf=%0b",
                     name, q, overflow, exp_q, exp_ovf);
        end
    endtask

    // Reference model: plain integer arithmetic on the count.
    int  m_q;
    bit  m_loaded;
    bit  m_ovf;

    function automatic void model_edge(logic [7:0] va, logic [7:0] vb, logic vu, logic vd);
        int t;
        if (!m_loaded) begin
            m_q = va; m_ovf = 0; m_loaded = 1;
        end else if (vu && !vd) begin
            t = m_q + vb;
            m_ovf = (t > 255);
            m_q = t % 256;
        end else if (vd && !vu) begin
            t = m_q - vb;
            m_ovf = (t < 0);
            m_q = (t + 256) % 256;
        end else begin
            m_ovf = 0;
        end
    endfunction

    initial begin
        // Wrap up from 250 by 10
        vecs.push_back(mk(0, 250, 10, 1, 0,   0, 0));
        vecs.push_back(mk(1, 250, 10, 1, 0, 250, 0));
        vecs.push_back(mk(1, 250, 10, 1, 0,   4, 1));
        vecs.push_back(mk(1, 250, 10, 1, 0,  14, 0));
        // Wrap down from 5 by 10
        vecs.push_back(mk(0,   5, 10, 0, 1,   0, 0));
        vecs.push_back(mk(1,   5, 10, 0, 1,   5, 0));
        vecs.push_back(mk(1,   5, 10, 0, 1, 251, 1));
        vecs.push_back(mk(1,   5, 10, 0, 1, 241, 0));
        // Exact boundaries
        vecs.push_back(mk(0, 246, 10, 1, 0,   0, 0));
        vecs.push_back(mk(1, 246, 10, 1, 0, 246, 0));
        vecs.push_back(mk(1, 246, 10, 1, 0,   0, 1));
        vecs.push_back(mk(0,  10, 10, 0, 1,   0, 0));
        vecs.push_back(mk(1,  10, 10, 0, 1,  10, 0));
        vecs.push_back(mk(1,  10, 10, 0, 1,   0, 0));
        vecs.push_back(mk(1,  10, 10, 0, 1, 246, 1));
        vecs.push_back(mk(0, 245, 10, 1, 0,   0, 0));
        vecs.push_back(mk(1, 245, 10, 1, 0, 245, 0));
        vecs.push_back(mk(1, 245, 10, 1, 0, 255, 0));
        // Hold with both and neither request
        vecs.push_back(mk(0, 100,  5, 0, 0,   0, 0));
        vecs.push_back(mk(1, 100,  5, 1, 1, 100, 0));
        vecs.push_back(mk(1, 100,  5, 1, 1, 100, 0));
        vecs.push_back(mk(1, 100,  5, 1, 1, 100, 0));
        vecs.push_back(mk(1, 100,  5, 1, 1, 100, 0));
        vecs.push_back(mk(1, 100,  5, 0, 0, 100, 0));
        vecs.push_back(mk(1, 100,  5, 0, 0, 100, 0));
        vecs.push_back(mk(1, 100,  5, 0, 0, 100, 0));
        // Zero step and stale a
        vecs.push_back(mk(0,   7,  0, 1, 0,   0, 0));
        vecs.push_back(mk(1,   7,  0, 1, 0,   7, 0));
        vecs.push_back(mk(1,  99,  0, 1, 0,   7, 0));
        vecs.push_back(mk(1,  99,  0, 1, 0,   7, 0));
        vecs.push_back(mk(1,  99,  0, 1, 0,   7, 0));
        vecs.push_back(mk(1,  99,  0, 1, 0,   7, 0));
        vecs.push_back(mk(1,  99,  0, 0, 1,   7, 0));
        vecs.push_back(mk(1,  99,  3, 1, 0,  10, 0));

        // Outputs must be zero while reset is held at time zero
        #1 chk("reset_state", 8'd0, 1'b0);

        foreach (vecs[i]) begin
            rst = vecs[i].rst; a = vecs[i].a; b = vecs[i].b;
            up = vecs[i].up; dn = vecs[i].dn;
            @(posedge clk); #1;
            chk($sformatf("vec%0d", i), vecs[i].exp_q, vecs[i].exp_ovf);
        end

        // Async reset mid-count, then reload of a
        rst = 0; a = 8'd20; b = 8'd1; up = 1; dn = 0;
        @(posedge clk); #1;
        rst = 1;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            chk($sformatf("areset_count%0d", k), 8'(20 + k), 1'b0);
        end
        #3 rst = 0;
        #1 chk("areset_immediate", 8'd0, 1'b0);
        @(posedge clk); #1;
        chk("areset_held_edge", 8'd0, 1'b0);
        #2 rst = 1;
        #1 chk("release_no_change", 8'd0, 1'b0);
        @(posedge clk); #1;
        chk("areset_reload", 8'd20, 1'b0);
        @(posedge clk); #1;
        chk("areset_recount", 8'd21, 1'b0);

        // Random traffic against the model, with occasional async resets
        rst = 0; #1;
        m_q = 0; m_ovf = 0; m_loaded = 0;
        chk("rand_reset", 8'(m_q), m_ovf);
        rst = 1;
        for (int n = 0; n < 400; n++) begin
            a  = 8'($urandom_range(0, 255));
            b  = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(0, 255));
            up = 1'($urandom_range(0, 1));
            dn = 1'($urandom_range(0, 1));
            @(posedge clk);
            model_edge(a, b, up, dn);
            #1 chk($sformatf("rand%0d", n), 8'(m_q), m_ovf);
            if ($urandom_range(0, 39) == 0) begin
                #2 rst = 0;
                m_q = 0; m_ovf = 0; m_loaded = 0;
                #1 chk($sformatf("rand_areset%0d", n), 8'(m_q), m_ovf);
                rst = 1;
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
